// File: rtl/counter_seq_pkg.sv
// Shared definitions for the loadable counter sequencer.
//   seq_state_t   : sequencer FSM state encoding (IDLE=0, LOAD=1, RUN=2)
//   DEFAULT_WIDTH : default counter / command data width
package counter_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/loadable_counter_sequencer.sv
// Control stage for an external loadable up-counter.
// Accepts a {start, terminal, periodic} command, loads the counter with
// start, lets it count on step_en, and reports each arrival at terminal
// with a one-cycle tick. Periodic commands reload and repeat; one-shot
// commands return to idle with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cmd_valid/ready : command handshake; a command transfers in a cycle
//                     where both are high (and abort is low). cmd_ready
//                     is high only in IDLE and does not depend on
//                     cmd_valid; the command fields must be stable while
//                     cmd_valid is high.
//   cmd_start       : value loaded into the counter
//   cmd_terminal    : count value that ends a period
//   cmd_periodic    : 1 = auto-reload, 0 = one-shot
//   step_en         : count qualifier forwarded to the counter in RUN
//   abort           : synchronous stop, overrides everything else
//   ctr_load        : counter load pin
//   ctr_enable      : counter enable pin
//   ctr_data        : counter parallel data (captured start value)
//   ctr_count       : counter's registered count
//   busy            : high in LOAD or RUN
//   tick            : one-cycle pulse per terminal hit
//   done            : one-cycle pulse at the end of a one-shot
//   state           : current FSM state, exposed for observation
module loadable_counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_terminal,
    input  logic             cmd_periodic,
    input  logic             step_en,
    input  logic             abort,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic [WIDTH-1:0] ctr_data,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output seq_state_t       state
);

    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] term_q;
    logic             per_q;
    logic             hit;

    // Comparison uses the count alone, so a hit is seen even while
    // step_en is low.
    assign hit = (ctr_count == term_q);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == LOAD) || (state == RUN);
    assign ctr_data  = start_q;

    // Abort gates the counter pins combinationally so the counter is
    // frozen in the very cycle abort is raised. The enable is dropped on
    // hit so the counter parks on the terminal value.
    assign ctr_load   = (state == LOAD) && !abort;
    assign ctr_enable = (state == RUN) && step_en && !hit && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= '0;
            term_q  <= '0;
            per_q   <= 1'b0;
            tick    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            start_q <= cmd_start;
                            term_q  <= cmd_terminal;
                            per_q   <= cmd_periodic;
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (hit) begin
                            tick <= 1'b1;
                            if (per_q) begin
                                state <= LOAD;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loadable_counter_sequencer.sv
// Directed bench for loadable_counter_sequencer with a loadable counter
// model attached to its counter pins. Cycle numbers in the comments count
// from the handshake cycle (cycle 0) of each command.
module tb_loadable_counter_sequencer;
    import counter_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_terminal;
    logic       cmd_periodic;
    logic       step_en;
    logic       abort;
    logic       ctr_load;
    logic       ctr_enable;
    logic [7:0] ctr_data;
    logic [7:0] ctr_count;
    logic       busy;
    logic       tick;
    logic       done;
    seq_state_t state;

    int n_assert = 0;
    int n_fail   = 0;

    loadable_counter_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_terminal (cmd_terminal),
        .cmd_periodic (cmd_periodic),
        .step_en      (step_en),
        .abort        (abort),
        .ctr_load     (ctr_load),
        .ctr_enable   (ctr_enable),
        .ctr_data     (ctr_data),
        .ctr_count    (ctr_count),
        .busy         (busy),
        .tick         (tick),
        .done         (done),
        .state        (state)
    );

    // Loadable up-counter sharing the sequencer's reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_count <= 8'd0;
        end else if (ctr_load) begin
            ctr_count <= ctr_data;
        end else if (ctr_enable) begin
            ctr_count <= ctr_count + 8'd1;
        end
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command in this cycle (cycle 0) and check it is offered ready.
    task automatic send(input logic [7:0] s, input logic [7:0] t, input logic p);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_start    = s;
        cmd_terminal = t;
        cmd_periodic = p;
        #1;
        chk1("send_ready", cmd_ready, 1'b1);
    endtask

    task automatic cyc();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_start    = 8'd0;
        cmd_terminal = 8'd0;
        cmd_periodic = 1'b0;
        step_en      = 1'b1;
        abort        = 1'b0;
        #1;
        // Reset values
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_load", ctr_load, 1'b0);
        chk1("rst_enable", ctr_enable, 1'b0);
        chk8("rst_data", ctr_data, 8'd0);
        chk8("rst_count", ctr_count, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // One-shot 3 -> 7: hit at cycle 6, tick/done at cycle 7 only.
        send(8'd3, 8'd7, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            #1;
            chk1("os_load", ctr_load, c == 1);
            chk1("os_enable", ctr_enable, c >= 2 && c <= 5);
            chk1("os_busy", busy, c <= 6);
            chk1("os_ready", cmd_ready, c >= 7);
            chk1("os_tick", tick, c == 7);
            chk1("os_done", done, c == 7);
            if (c == 1) chk8("os_data", ctr_data, 8'd3);
            if (c >= 2) chk8("os_count", ctr_count, (c <= 6) ? 8'(c + 1) : 8'd7);
        end

        // Periodic 250 -> 2 through the wrap: N=8, period 10.
        send(8'd250, 8'd2, 1'b1);
        for (int c = 1; c <= 21; c++) begin
            cyc();
            #1;
            chk1("per_load", ctr_load, ((c - 1) % 10) == 0);
            chk1("per_tick", tick, c == 11 || c == 21);
            chk1("per_busy", busy, 1'b1);
            if (((c - 1) % 10) != 0)
                chk8("per_count", ctr_count, 8'(249 + ((c - 1) % 10)));
        end
        // Cycle 22 is RUN at 250: abort freezes counter pins at once.
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk1("per_abort_enable", ctr_enable, 1'b0);
        chk1("per_abort_busy", busy, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk1("per_abort_idle", busy, 1'b0);
        chk1("per_abort_ready", cmd_ready, 1'b1);
        chk1("per_abort_tick", tick, 1'b0);
        chk8("per_abort_count", ctr_count, 8'd250);

        // start == terminal, periodic: LOAD/RUN alternate, tick every 2.
        send(8'd5, 8'd5, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            #1;
            chk1("eq_load", ctr_load, (c % 2) == 1);
            chk1("eq_tick", tick, (c % 2) == 1 && c >= 3);
            chk1("eq_enable", ctr_enable, 1'b0);
            if ((c % 2) == 0) chk8("eq_count", ctr_count, 8'd5);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk1("eq_abort_load", ctr_load, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk1("eq_abort_idle", busy, 1'b0);
        chk1("eq_abort_tick", tick, 1'b0);

        // step_en at 50% duty, one-shot 0 -> 4: hit at cycle 9 with step_en low.
        step_en = 1'b0;
        send(8'd0, 8'd4, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            step_en = ((c % 2) == 0);
            #1;
            chk1("duty_enable", ctr_enable, (c % 2) == 0 && c >= 2 && c <= 8);
            chk1("duty_tick", tick, c == 10);
            chk1("duty_done", done, c == 10);
            if (c >= 2 && c <= 9) chk8("duty_count", ctr_count, 8'((c - 1) / 2));
            if (c >= 2) chk1("duty_le_term", ctr_count <= 8'd4, 1'b1);
        end
        step_en = 1'b1;

        // Abort in RUN at count 5 of 0 -> 9, new command on the next cycle.
        send(8'd0, 8'd9, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            #1;
            if (c >= 2) chk8("ab_count", ctr_count, 8'(c - 2));
        end
        cyc();
        abort = 1'b1;
        #1;
        chk8("ab_count5", ctr_count, 8'd5);
        chk1("ab_enable", ctr_enable, 1'b0);
        @(negedge clk);
        abort        = 1'b0;
        cmd_valid    = 1'b1;
        cmd_start    = 8'd10;
        cmd_terminal = 8'd11;
        cmd_periodic = 1'b0;
        #1;
        chk1("ab_idle", busy, 1'b0);
        chk1("ab_tick", tick, 1'b0);
        chk1("ab_done", done, 1'b0);
        chk1("ab_ready", cmd_ready, 1'b1);
        chk8("ab_hold", ctr_count, 8'd5);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            #1;
            chk1("ab2_load", ctr_load, c == 1);
            chk1("ab2_tick", tick, c == 4);
            chk1("ab2_done", done, c == 4);
            if (c >= 2) chk8("ab2_count", ctr_count, (c == 2) ? 8'd10 : 8'd11);
        end

        // Abort in IDLE blocks acceptance.
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_start    = 8'd1;
        cmd_terminal = 8'd3;
        abort        = 1'b1;
        #1;
        chk1("ib_load", ctr_load, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1;
        chk1("ib_busy", busy, 1'b0);
        chk1("ib_load2", ctr_load, 1'b0);

        // Reset mid-RUN, then a normal command.
        send(8'd20, 8'd30, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            #1;
        end
        chk8("mr_count", ctr_count, 8'd23);
        rst_n = 1'b0;
        #1;
        chk1("mr_ready", cmd_ready, 1'b1);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_enable", ctr_enable, 1'b0);
        chk1("mr_load", ctr_load, 1'b0);
        chk1("mr_tick", tick, 1'b0);
        chk8("mr_data", ctr_data, 8'd0);
        chk8("mr_count0", ctr_count, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd1, 8'd2, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            #1;
            chk1("mr2_load", ctr_load, c == 1);
            chk1("mr2_tick", tick, c == 4);
            chk1("mr2_done", done, c == 4);
            chk1("mr2_ready", cmd_ready, c >= 4);
            if (c >= 2) chk8("mr2_count", ctr_count, (c == 2) ? 8'd1 : 8'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/loadable_counter_sequencer.md
# loadable_counter_sequencer

Control stage that drives a loadable up-counter and watches its count. It accepts a command {start, terminal, periodic} over a valid/ready handshake, loads the counter with `start`, and enables counting while `step_en` is high. When the count equals `terminal` it emits a one-cycle `tick`, then either reloads (periodic mode) or returns to idle and pulses `done` (one-shot mode). It sits directly upstream of the counter, driving its load/enable/data pins, and consumes the counter's count output.

## Interface
- `WIDTH`, default 8: counter and command data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_start`  in  WIDTH  value loaded into the counter.
- `cmd_terminal`  in  WIDTH  count value that ends a period.
- `cmd_periodic`  in  1  1 = auto-reload, 0 = one-shot.
- `step_en`  in  1  count qualifier; passed to the counter while running.
- `abort`  in  1  synchronous stop; highest priority.
- `ctr_load`  out  1  to the counter's load pin.
- `ctr_enable`  out  1  to the counter's enable pin.
- `ctr_data`  out  WIDTH  to the counter's parallel data input; equals `start_q`.
- `ctr_count`  in  WIDTH  counter's registered count.
- `busy`  out  1  high in LOAD or RUN.
- `tick`  out  1  registered one-cycle pulse per terminal hit.
- `done`  out  1  registered one-cycle pulse at the end of a one-shot.

## Operation
- States are IDLE, LOAD and RUN. Reset state is IDLE.
- `cmd_ready` = (state == IDLE), so it is 1 during and after reset.
- **IDLE:** on `cmd_valid & cmd_ready & !abort`, capture `start_q`, `term_q` and `per_q`, then go to LOAD.
- **LOAD:** drive `ctr_load=1` and `ctr_enable=0` for exactly one cycle, then go to RUN.
- **RUN:**
  - `hit` = (`ctr_count == term_q`).
  - `ctr_enable = step_en & !hit`; the counter holds at `terminal`.
  - On `hit`: `tick<=1`. If `per_q` is set, go to LOAD. Otherwise go to IDLE and set `done<=1`.
- **abort:** from any state, go to IDLE next cycle. No `tick` or `done` for the cycle in which `abort` is high. `ctr_load` and `ctr_enable` are forced to 0 combinationally. `abort` in IDLE blocks command acceptance.
- **Arithmetic:** the counter wraps modulo 2^WIDTH. Steps per period are N = (terminal − start) mod 2^WIDTH, so `terminal < start` is legal and counts through the wrap.
- **start == terminal:** N=0. `hit` occurs in the first RUN cycle.
- **Reset values:** state=IDLE; `start_q`, `term_q`, `per_q` = 0; `ctr_load`, `ctr_enable`, `busy`, `tick`, `done` = 0; `ctr_data` = 0; `cmd_ready` = 1.
- **Reset mid-operation:** immediate return to IDLE with all outputs at reset values. The counter shares `rst_n` and returns to 0.

## Timing
- Cycle 0: handshake. Cycle 1: LOAD, `ctr_load=1`. Cycle 2: RUN with `ctr_count=start`.
- With `step_en` held at 1: `hit` at cycle 2+N, `tick` high at cycle 3+N.
- Periodic: LOAD at 3+N, so the period is N+2 cycles (minimum 2, when N=0).
- One-shot: `done` and `tick` are high together at cycle 3+N, and `cmd_ready` is 1 at 3+N.
- `step_en` low stalls RUN without changing state. The `hit` check uses `ctr_count` only, so `hit` is detected even when `step_en` is low.
- `busy` is the registered state decode and matches LOAD/RUN cycle-exactly.

## Structure
- Shared package `counter_seq_pkg`:
  - `seq_state_t` 2-bit enum: IDLE=0, LOAD=1, RUN=2.
  - Default `WIDTH` constant.
- No sub-module. The comparator, FSM and command registers are in one module.
- The bench instantiates the team's loadable counter alongside this block.

## Test plan
- One-shot, WIDTH=8, start=3, terminal=7, `step_en`=1: `tick` and `done` high at cycle 7 only; counter holds 7; `cmd_ready` returns at cycle 7.
- Periodic, start=250, terminal=2 (wrap, N=8): `tick` every 10 cycles; count sequence 250…255,0,1,2.
- start=terminal=5, periodic: `tick` every 2 cycles; `ctr_load` toggles 1/0.
- `step_en` 50% duty, start=0, terminal=4: `tick` only after 4 qualified steps; count never exceeds 4.
- Abort asserted in RUN at count 5 of 0→9: IDLE next cycle; no `tick` or `done`; a new command is accepted the following cycle.
- `rst_n` low mid-RUN: all outputs at reset values asynchronously; `cmd_ready`=1; the next command runs normally.
